aes_round_ctrl: RTL and testbench
=================================

AES_ROUND_CTRL -- requirements
Module: aes_round_ctrl

Interface
REQ-001 Parameter NUM_ROUNDS, default 10, meaning: number of cipher rounds sequenced per block; legal range 1..14.
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 rst_n  input  1  reset, synchronous, active-low.
REQ-004 in_valid  input  1  upstream presents a 128-bit block.
REQ-005 in_ready  output  1  controller can accept a block.
REQ-006 in_block  input  128  raw block, byte 15 in bits [127:120].
REQ-007 rawstring  output  128  captured block; feeds the matrixify instance.
REQ-008 load_state  output  1  datapath loads the matrixified block XOR round key 0 this cycle.
REQ-009 round_en  output  1  datapath applies one round this cycle.
REQ-010 round_num  output  4  round-key index for the current cycle.
REQ-011 last_round  output  1  current round omits MixColumns.
REQ-012 out_valid  output  1  datapath state holds a finished block.
REQ-013 out_ready  input  1  downstream consumes the finished block.
REQ-014 busy  output  1  high in every state except IDLE.
REQ-015 blk_count  output  16  count of completed output handshakes.

Function
REQ-016 The FSM SHALL have four states: IDLE, LOAD, ROUND and DONE.
REQ-017 IDLE: in_ready=1; on in_valid, block_q <= in_block, then go to LOAD.
REQ-018 LOAD: lasts exactly one cycle; load_state=1, round_num=0, round counter <= 1, then go to ROUND.
REQ-019 ROUND: round_en=1 and round_num=counter; the counter increments each cycle.
REQ-020 ROUND: last_round=1 only when counter==NUM_ROUNDS; in that cycle go to DONE instead of incrementing.
REQ-021 DONE: out_valid=1 and is held until out_ready=1.
REQ-022 DONE: on the out_valid&out_ready cycle, go to IDLE and increment blk_count.
REQ-023 in_ready SHALL be 0 in LOAD, ROUND and DONE; a block is accepted at the earliest one cycle after the output handshake.
REQ-024 Latency: accept at edge T; LOAD in cycle T+1; rounds in T+2..T+NUM_ROUNDS+1; out_valid from T+NUM_ROUNDS+2.
REQ-025 round_num SHALL be 0 in IDLE and DONE and SHALL never exceed NUM_ROUNDS; the counter SHALL never wrap.
REQ-026 blk_count SHALL saturate at 16'hFFFF.
REQ-027 rawstring SHALL equal block_q, which is updated only on the IDLE accept.
REQ-028 load_state, round_en and out_valid SHALL be mutually exclusive; at most one is high in any cycle.
REQ-029 in_valid arriving while busy SHALL be ignored and SHALL NOT corrupt block_q.
REQ-030 out_ready while not in DONE SHALL have no effect.

Reset
REQ-031 When rst_n=0 at a clock edge: state=IDLE, counter=0, block_q=0, blk_count=0.
REQ-032 Outputs after reset: in_ready=1; load_state, round_en, last_round, out_valid and busy = 0; round_num=0; rawstring=0.
REQ-033 Reset asserted mid-block (LOAD, ROUND or DONE) SHALL abort the block with no output handshake and no blk_count change.

Structure
REQ-034 Shared package aes_pkg SHALL hold the FSM state enum, AES_BLOCK_W=128, AES_MAX_ROUNDS=14 and the round_num width (4).
REQ-035 The only sub-module SHALL be one matrixify instance, driven by rawstring, with its 4x4 byte matrix exported to the datapath.
REQ-036 The round datapath and key schedule are outside this block.

Verification
REQ-037 Reset then single block: in_block=128'h121b1904637a127974620d1577056458, in_valid for 1 cycle, out_ready=1 -> one load_state pulse, round_en for 10 cycles with round_num 1..10, last_round only at 10, out_valid 12 cycles after accept, blk_count=1; matrix[3][3]=8'h12, matrix[0][0]=8'h58.
REQ-038 Backpressure: out_ready=0 for 5 cycles in DONE -> out_valid stays high, in_ready stays 0, blk_count unchanged; blk_count increments once when out_ready rises.
REQ-039 Busy injection: second in_valid with in_block=128'hFFFF...FF during ROUND -> ignored; rawstring keeps the first block; no extra load_state.
REQ-040 Mid-round reset: rst_n=0 at round_num=5 -> next cycle IDLE, all outputs at reset values, blk_count=0.
REQ-041 Parameter corner: NUM_ROUNDS=1 -> LOAD, then a single ROUND cycle with round_num=1 and last_round=1, then DONE.
REQ-042 Back-to-back traffic: 3 blocks with in_valid held high and out_ready=1 -> accepts spaced NUM_ROUNDS+3 cycles apart, blk_count=3.

Source files
------------

// File: rtl/aes_pkg.sv
// Shared AES controller definitions.
//   AES_BLOCK_W    : cipher block width in bits
//   AES_MAX_ROUNDS : largest supported round count (AES-256)
//   ROUND_W        : width of the round-key index
//   state_t        : round controller FSM encoding
//   matrix_t       : 4x4 byte state matrix, indexed [row][col]
package aes_pkg;
  localparam int unsigned AES_BLOCK_W    = 128;
  localparam int unsigned AES_MAX_ROUNDS = 14;
  localparam int unsigned ROUND_W        = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    ROUND = 2'd2,
    DONE  = 2'd3
  } state_t;

  typedef logic [3:0][3:0][7:0] matrix_t;
endpackage

// File: rtl/aes_round_ctrl_matrixify.sv
// matrixify: reshapes a raw 128-bit block into the AES 4x4 byte state.
//   rawstring : raw block, byte 15 in bits [127:120], byte 0 in [7:0]
//   matrix    : matrix[row][col] = byte (col*4 + row), AES column-major
module matrixify
  import aes_pkg::*;
(
  input  logic [AES_BLOCK_W-1:0] rawstring,
  output matrix_t                matrix
);

  always_comb begin
    matrix = '0;
    for (int unsigned c = 0; c < 4; c++) begin
      for (int unsigned r = 0; r < 4; r++) begin
        matrix[r][c] = rawstring[(c*4 + r)*8 +: 8];
      end
    end
  end

endmodule

// File: rtl/aes_round_ctrl.sv
// aes_round_ctrl: sequences one AES block through load, NUM_ROUNDS rounds
// and an output handshake; the round datapath and key schedule live outside.
//   clk, rst_n  : clock, synchronous active-low reset
//   in_valid    : upstream block available (in_block)
//   in_ready    : controller idle and able to accept a block
//   rawstring   : captured block
//   matrix      : captured block as 4x4 byte matrix for the datapath
//   load_state  : datapath loads matrix XOR round key 0
//   round_en    : datapath applies one round
//   round_num   : round-key index for this cycle
//   last_round  : current round skips MixColumns
//   out_valid   : datapath holds a finished block; out_ready consumes it
//   busy        : not idle
//   blk_count   : saturating count of output handshakes
module aes_round_ctrl
  import aes_pkg::*;
#(
  parameter int unsigned NUM_ROUNDS = 10
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [AES_BLOCK_W-1:0] in_block,
  output logic [AES_BLOCK_W-1:0] rawstring,
  output matrix_t                matrix,
  output logic                   load_state,
  output logic                   round_en,
  output logic [ROUND_W-1:0]     round_num,
  output logic                   last_round,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic                   busy,
  output logic [15:0]            blk_count
);

  localparam logic [ROUND_W-1:0] LAST_RND = ROUND_W'(NUM_ROUNDS);

  state_t                   state, state_nxt;
  logic [ROUND_W-1:0]       counter, counter_nxt;
  logic [AES_BLOCK_W-1:0]   block_q;
  logic                     accept;

  assign accept    = (state == IDLE) && in_valid;
  assign rawstring = block_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      counter   <= '0;
      block_q   <= '0;
      blk_count <= '0;
    end else begin
      state   <= state_nxt;
      counter <= counter_nxt;
      if (accept) begin
        block_q <= in_block;
      end
      if (out_valid && out_ready && (blk_count != '1)) begin
        blk_count <= blk_count + 16'd1;
      end
    end
  end

  always_comb begin
    state_nxt   = state;
    counter_nxt = counter;
    in_ready    = 1'b0;
    load_state  = 1'b0;
    round_en    = 1'b0;
    round_num   = '0;
    last_round  = 1'b0;
    out_valid   = 1'b0;
    busy        = 1'b1;
    case (state)
      IDLE: begin
        in_ready    = 1'b1;
        busy        = 1'b0;
        counter_nxt = '0;
        if (in_valid) begin
          state_nxt = LOAD;
        end
      end
      LOAD: begin
        load_state  = 1'b1;
        counter_nxt = ROUND_W'(1);
        state_nxt   = ROUND;
      end
      ROUND: begin
        round_en  = 1'b1;
        round_num = counter;
        if (counter == LAST_RND) begin
          // Final round: clear rather than increment so the counter never wraps.
          last_round  = 1'b1;
          counter_nxt = '0;
          state_nxt   = DONE;
        end else begin
          counter_nxt = counter + ROUND_W'(1);
        end
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) begin
          state_nxt = IDLE;
        end
      end
      default: begin
        state_nxt   = IDLE;
        counter_nxt = '0;
      end
    endcase
  end

  matrixify u_matrixify (
    .rawstring (block_q),
    .matrix    (matrix)
  );

endmodule

// File: tb/tb_aes_round_ctrl.sv
// Directed bench for aes_round_ctrl: a NUM_ROUNDS=10 instance for the main
// scenarios and a NUM_ROUNDS=1 instance for the single-round corner.
module tb_aes_round_ctrl;
  import aes_pkg::*;

  localparam logic [127:0] B1 = 128'h121b1904637a127974620d1577056458;
  localparam logic [127:0] B2 = 128'h0f0e0d0c0b0a09080706050403020100;
  localparam logic [127:0] B3 = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] B4 = 128'hdeadbeefcafef00d0123456789abcdef;

  logic clk = 1'b0;
  logic rst_n;

  logic         in_valid, in_ready, load_state, round_en, last_round;
  logic         out_valid, out_ready, busy;
  logic [127:0] in_block, rawstring;
  logic [3:0]   round_num;
  logic [15:0]  blk_count;
  matrix_t      matrix;

  logic         in_valid1, in_ready1, load_state1, round_en1, last_round1;
  logic         out_valid1, out_ready1, busy1;
  logic [127:0] in_block1, rawstring1;
  logic [3:0]   round_num1;
  logic [15:0]  blk_count1;
  matrix_t      matrix1;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  aes_round_ctrl #(.NUM_ROUNDS(10)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_block(in_block), .rawstring(rawstring), .matrix(matrix),
    .load_state(load_state), .round_en(round_en), .round_num(round_num),
    .last_round(last_round), .out_valid(out_valid), .out_ready(out_ready),
    .busy(busy), .blk_count(blk_count)
  );

  aes_round_ctrl #(.NUM_ROUNDS(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid1), .in_ready(in_ready1),
    .in_block(in_block1), .rawstring(rawstring1), .matrix(matrix1),
    .load_state(load_state1), .round_en(round_en1), .round_num(round_num1),
    .last_round(last_round1), .out_valid(out_valid1), .out_ready(out_ready1),
    .busy(busy1), .blk_count(blk_count1)
  );

  // At most one of load_state/round_en/out_valid in any cycle out of reset.
  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      checks++;
      if ($countones({load_state, round_en, out_valid}) > 1) begin
        errors++;
        $display("FAIL exclusive: load=%b round=%b out=%b required at most one high",
                 load_state, round_en, out_valid);
      end
    end
  end

  task automatic test_reset();
    rst_n = 1'b0;
    in_valid = 1'b0; in_block = '0; out_ready = 1'b0;
    in_valid1 = 1'b0; in_block1 = '0; out_ready1 = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    checks++;
    if ({in_ready, busy, load_state, round_en, last_round, out_valid} !== 6'b100000) begin
      errors++;
      $display("FAIL reset_flags: got %b required 100000",
               {in_ready, busy, load_state, round_en, last_round, out_valid});
    end
    checks++;
    if (round_num !== 4'd0 || rawstring !== '0 || blk_count !== 16'd0) begin
      errors++;
      $display("FAIL reset_values: round_num=%0d rawstring=%h blk_count=%0d required 0",
               round_num, rawstring, blk_count);
    end
    checks++;
    if (in_ready1 !== 1'b1 || busy1 !== 1'b0 || blk_count1 !== 16'd0) begin
      errors++;
      $display("FAIL reset_dut1: in_ready=%b busy=%b blk_count=%0d required 1 0 0",
               in_ready1, busy1, blk_count1);
    end
  endtask

  task automatic test_single_block();
    in_block = B1; in_valid = 1'b1; out_ready = 1'b1;
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL single_ready: got %b required 1", in_ready);
    end
    @(negedge clk);
    in_valid = 1'b0;
    checks++;
    if (load_state !== 1'b1 || round_num !== 4'd0 || in_ready !== 1'b0 || busy !== 1'b1) begin
      errors++;
      $display("FAIL single_load: load=%b rn=%0d in_ready=%b busy=%b required 1 0 0 1",
               load_state, round_num, in_ready, busy);
    end
    for (int i = 1; i <= 10; i++) begin
      @(negedge clk);
      checks++;
      if (round_en !== 1'b1 || round_num !== 4'(i) || last_round !== (i == 10) ||
          load_state !== 1'b0 || out_valid !== 1'b0) begin
        errors++;
        $display("FAIL single_round%0d: en=%b rn=%0d last=%b load=%b ov=%b required 1 %0d %b 0 0",
                 i, round_en, round_num, last_round, load_state, out_valid, i, (i == 10));
      end
    end
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b1 || round_en !== 1'b0 || round_num !== 4'd0 || in_ready !== 1'b0) begin
      errors++;
      $display("FAIL single_done: ov=%b en=%b rn=%0d in_ready=%b required 1 0 0 0",
               out_valid, round_en, round_num, in_ready);
    end
    checks++;
    if (matrix[3][3] !== 8'h12 || matrix[0][0] !== 8'h58 || rawstring !== B1) begin
      errors++;
      $display("FAIL single_matrix: m33=%h m00=%h raw=%h required 12 58 %h",
               matrix[3][3], matrix[0][0], rawstring, B1);
    end
    @(negedge clk);
    checks++;
    if (blk_count !== 16'd1 || out_valid !== 1'b0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL single_count: blk=%0d ov=%b in_ready=%b required 1 0 1",
               blk_count, out_valid, in_ready);
    end
  endtask

  task automatic test_one_round();
    in_block1 = B1; in_valid1 = 1'b1; out_ready1 = 1'b1;
    @(negedge clk);
    in_valid1 = 1'b0;
    checks++;
    if (load_state1 !== 1'b1 || round_num1 !== 4'd0) begin
      errors++;
      $display("FAIL one_load: load=%b rn=%0d required 1 0", load_state1, round_num1);
    end
    @(negedge clk);
    checks++;
    if (round_en1 !== 1'b1 || round_num1 !== 4'd1 || last_round1 !== 1'b1) begin
      errors++;
      $display("FAIL one_round: en=%b rn=%0d last=%b required 1 1 1",
               round_en1, round_num1, last_round1);
    end
    @(negedge clk);
    checks++;
    if (out_valid1 !== 1'b1 || round_en1 !== 1'b0 || round_num1 !== 4'd0) begin
      errors++;
      $display("FAIL one_done: ov=%b en=%b rn=%0d required 1 0 0",
               out_valid1, round_en1, round_num1);
    end
    @(negedge clk);
    checks++;
    if (blk_count1 !== 16'd1 || in_ready1 !== 1'b1) begin
      errors++;
      $display("FAIL one_count: blk=%0d in_ready=%b required 1 1", blk_count1, in_ready1);
    end
  endtask

  task automatic test_backpressure();
    in_block = B2; in_valid = 1'b1; out_ready = 1'b0;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (10) @(negedge clk);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checks++;
      if (out_valid !== 1'b1 || in_ready !== 1'b0 || blk_count !== 16'd1) begin
        errors++;
        $display("FAIL bp_hold%0d: ov=%b in_ready=%b blk=%0d required 1 0 1",
                 i, out_valid, in_ready, blk_count);
      end
    end
    out_ready = 1'b1;
    @(negedge clk);
    checks++;
    if (blk_count !== 16'd2 || out_valid !== 1'b0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL bp_release: blk=%0d ov=%b in_ready=%b required 2 0 1",
               blk_count, out_valid, in_ready);
    end
  endtask

  task automatic test_busy_injection();
    in_block = B3; in_valid = 1'b1; out_ready = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    for (int i = 1; i <= 10; i++) begin
      @(negedge clk);
      checks++;
      if (round_num !== 4'(i) || load_state !== 1'b0 || rawstring !== B3) begin
        errors++;
        $display("FAIL busy_round%0d: rn=%0d load=%b raw=%h required %0d 0 %h",
                 i, round_num, load_state, rawstring, i, B3);
      end
      if (i == 3) begin
        in_valid = 1'b1;
        in_block = '1;
      end
      if (i == 5) in_valid = 1'b0;
    end
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b1 || rawstring !== B3) begin
      errors++;
      $display("FAIL busy_done: ov=%b raw=%h required 1 %h", out_valid, rawstring, B3);
    end
    @(negedge clk);
    checks++;
    if (blk_count !== 16'd3 || rawstring !== B3 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL busy_end: blk=%0d raw=%h in_ready=%b required 3 %h 1",
               blk_count, rawstring, in_ready, B3);
    end
  endtask

  task automatic test_mid_reset();
    in_block = B4; in_valid = 1'b1; out_ready = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (5) @(negedge clk);
    checks++;
    if (round_num !== 4'd5 || round_en !== 1'b1) begin
      errors++;
      $display("FAIL midrst_pre: rn=%0d en=%b required 5 1", round_num, round_en);
    end
    rst_n = 1'b0;
    @(negedge clk);
    checks++;
    if ({in_ready, busy, load_state, round_en, last_round, out_valid} !== 6'b100000 ||
        round_num !== 4'd0 || rawstring !== '0 || blk_count !== 16'd0) begin
      errors++;
      $display("FAIL midrst_post: flags=%b rn=%0d raw=%h blk=%0d required 100000 0 0 0",
               {in_ready, busy, load_state, round_en, last_round, out_valid},
               round_num, rawstring, blk_count);
    end
    rst_n = 1'b1;
  endtask

  task automatic test_back_to_back();
    int acc[3];
    int n;
    int cyc;
    n = 0;
    cyc = 0;
    in_block = B1; in_valid = 1'b1; out_ready = 1'b1;
    while (n < 3 && cyc < 100) begin
      if (in_ready === 1'b1) begin
        acc[n] = cyc;
        n++;
      end
      @(negedge clk);
      cyc++;
    end
    in_valid = 1'b0;
    checks++;
    if (n != 3) begin
      errors++;
      $display("FAIL b2b_accepts: got %0d accepts in %0d cycles required 3", n, cyc);
    end else begin
      checks++;
      if (acc[1] - acc[0] != 13 || acc[2] - acc[1] != 13) begin
        errors++;
        $display("FAIL b2b_spacing: got %0d,%0d required 13,13",
                 acc[1] - acc[0], acc[2] - acc[1]);
      end
    end
    repeat (12) @(negedge clk);
    checks++;
    if (blk_count !== 16'd3 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL b2b_count: blk=%0d in_ready=%b required 3 1", blk_count, in_ready);
    end
  endtask

  initial begin
    test_reset();
    test_single_block();
    test_one_round();
    test_backpressure();
    test_busy_injection();
    test_mid_reset();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
